// File: rtl/day_month_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | day_month_counter : calendar day/month counter with leap-year Feb, preset, |
// |                     year-carry pulse and gated databus.   Rev 1.0           |
// +----------------------------------------------------------------------------+
module day_month_counter #(
  parameter int START_DAY   = 1,
  parameter int START_MONTH = 1
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       tick_day,
  input  logic       load,
  input  logic [4:0] load_day,
  input  logic [3:0] load_month,
  input  logic [5:0] year,
  input  logic       enable,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic       year_inc,
  output logic       load_err,
  output logic [8:0] databus
);

  localparam logic [4:0] C_START_DAY   = 5'(START_DAY);
  localparam logic [3:0] C_START_MONTH = 4'(START_MONTH);

  function automatic logic [4:0] f_month_len(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: f_month_len = 5'd30;
      4'd2:                    f_month_len = leap ? 5'd29 : 5'd28;
      default:                 f_month_len = 5'd31;
    endcase
  endfunction

  logic [4:0] r_day;
  logic [3:0] r_month;
  logic       r_year_inc;
  logic       r_load_err;
  logic       r_armed;

  logic       w_leap;
  logic [4:0] w_cur_len;
  logic [4:0] w_load_len;
  logic       w_load_ok;
  logic [4:0] w_day_nxt;
  logic [3:0] w_month_nxt;
  logic       w_year_inc_nxt;
  logic       w_load_err_nxt;
  logic       w_unused_year;

  // Only the two LSBs of the year matter for the leap rule.
  assign w_unused_year = ^year[5:2];
  assign w_leap        = (year[1:0] == 2'd0);
  assign w_cur_len     = f_month_len(r_month, w_leap);
  assign w_load_len    = f_month_len(load_month, w_leap);
  assign w_load_ok     = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                         (load_day >= 5'd1) && (load_day <= w_load_len);

  always_comb begin
    w_day_nxt      = r_day;
    w_month_nxt    = r_month;
    w_year_inc_nxt = 1'b0;
    w_load_err_nxt = 1'b0;
    // r_armed swallows the first edge after reset release.
    if (r_armed) begin
      if (load) begin
        if (w_load_ok) begin
          w_day_nxt   = load_day;
          w_month_nxt = load_month;
        end else begin
          w_load_err_nxt = 1'b1;
        end
      end else if (tick_day) begin
        if (r_day >= w_cur_len) begin
          w_day_nxt = 5'd1;
          if (r_month >= 4'd12) begin
            w_month_nxt    = 4'd1;
            w_year_inc_nxt = 1'b1;
          end else begin
            w_month_nxt = r_month + 4'd1;
          end
        end else begin
          w_day_nxt = r_day + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_day      <= C_START_DAY;
      r_month    <= C_START_MONTH;
      r_year_inc <= 1'b0;
      r_load_err <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_day      <= w_day_nxt;
      r_month    <= w_month_nxt;
      r_year_inc <= w_year_inc_nxt;
      r_load_err <= w_load_err_nxt;
      r_armed    <= 1'b1;
    end
  end

  assign day      = r_day;
  assign month    = r_month;
  assign year_inc = r_year_inc;
  assign load_err = r_load_err;
  assign databus  = {r_month, r_day} & {9{enable}};

endmodule
`default_nettype wire
